// File: rtl/ram_byte_ctrl.sv
// ram_byte_ctrl: byte-lane word RAM with self-clearing after reset, registered read port and LED byte viewer
module ram_byte_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  localparam int LANES = DATA_W / 8,
  localparam int SEL_W = $clog2(LANES)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] Mem_Addr,
  input  logic              Mem_Write,
  input  logic              Mem_Read,
  input  logic [LANES-1:0]  Byte_En,
  input  logic [DATA_W-1:0] W_Data,
  input  logic [SEL_W-1:0]  MUX,
  output logic [DATA_W-1:0] R_Data,
  output logic              R_Valid,
  output logic              Ready,
  output logic [7:0]        LED
);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic clr, rd;
  logic [LANES-1:0] we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;

  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= clr ? cnt + 1'b1 : cnt;
    end

  always_comb state_nx = (state == CLEAR && &cnt) ? IDLE : state;

  // The clear engine owns the write port until every word has been zeroed
  always_comb begin
    clr   = state == CLEAR;
    Ready = state == IDLE;
    rd    = Ready && Mem_Read;
    we    = clr ? '1 : (Ready && Mem_Write ? Byte_En : '0);
    wa    = clr ? cnt : Mem_Addr;
    wd    = clr ? '0 : W_Data;
  end

  always_ff @(posedge Clk)
    for (int i = 0; i < LANES; i++)
      if (we[i]) mem[wa][8*i +: 8] <= wd[8*i +: 8];

  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      R_Data  <= '0;
      R_Valid <= 1'b0;
    end else begin
      R_Valid <= rd;
      if (rd) R_Data <= mem[Mem_Addr];
    end

  assign LED = 8'(R_Data >> {MUX, 3'b000});
endmodule

// File: tb/tb_ram_byte_ctrl.sv
// tb_ram_byte_ctrl: scoreboard bench for ram_byte_ctrl with directed vectors
module tb_ram_byte_ctrl;
  logic clk = 0, rst = 1;
  logic [5:0] addr = '0;
  logic wr = 0, rd = 0;
  logic [3:0] be = '0;
  logic [31:0] wdata = '0;
  logic [1:0] mux = '0;
  logic [31:0] r_data;
  logic r_valid, ready;
  logic [7:0] led;
  logic [31:0] exp_q [$];
  int total = 0, passed = 0;

  ram_byte_ctrl dut (
    .Clk(clk), .Rst(rst), .Mem_Addr(addr), .Mem_Write(wr), .Mem_Read(rd),
    .Byte_En(be), .W_Data(wdata), .MUX(mux), .R_Data(r_data),
    .R_Valid(r_valid), .Ready(ready), .LED(led)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  always @(negedge clk)
    if (r_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_rvalid", 32'(r_valid), 32'd0);
      else check("read_data", r_data, exp_q.pop_front());
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a; wdata = d; be = b; wr = 1;
    tick();
    wr = 0;
  endtask

  task automatic do_read(input logic [5:0] a, input logic [31:0] e);
    addr = a; rd = 1; exp_q.push_back(e);
    tick();
    rd = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdata"}, r_data, 32'd0);
    check({tag, "_rvalid"}, 32'(r_valid), 32'd0);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_led"}, 32'(led), 32'd0);
  endtask

  task automatic count_clear(input string tag);
    for (int k = 1; k <= 64; k++) begin
      tick();
      check(tag, 32'(ready), 32'(k == 64));
    end
  endtask

  task automatic drain;
    tick();
    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #2;
    check_reset_outputs("rst0");
    tick();
    tick();
    rst = 0;
    // Write and read held through the whole clear, including the edge that raises Ready
    addr = 6'd3; wdata = 32'hFFFF_FFFF; be = 4'hF; wr = 1; rd = 1;
    count_clear("ready_clear1");
    wr = 0; rd = 0;
    do_read(6'd0, 32'h0);
    do_read(6'd31, 32'h0);
    do_read(6'd63, 32'h0);
    do_read(6'd3, 32'h0);
    drain();
    do_write(6'd5, 32'hDEAD_BEEF, 4'hF);
    do_read(6'd5, 32'hDEAD_BEEF);
    tick();
    check("rvalid_single", 32'(r_valid), 32'd0);
    mux = 2'd0; #1 check("led0", 32'(led), 32'hEF);
    mux = 2'd1; #1 check("led1", 32'(led), 32'hBE);
    mux = 2'd2; #1 check("led2", 32'(led), 32'hAD);
    mux = 2'd3; #1 check("led3", 32'(led), 32'hDE);
    do_write(6'd5, 32'h1122_3344, 4'b0101);
    do_read(6'd5, 32'hDE22_BE44);
    do_write(6'd5, 32'hFFFF_FFFF, 4'b0000);
    do_read(6'd5, 32'hDE22_BE44);
    addr = 6'd5; wdata = 32'hCAFE_F00D; be = 4'hF; wr = 1; rd = 1;
    exp_q.push_back(32'hDE22_BE44);
    tick();
    wr = 0; rd = 0;
    do_read(6'd5, 32'hCAFE_F00D);
    do_write(6'd63, 32'h1234_5678, 4'hF);
    do_write(6'd0, 32'h0, 4'hF);
    do_read(6'd63, 32'h1234_5678);
    do_read(6'd5, 32'hCAFE_F00D);
    do_read(6'd0, 32'h0);
    drain();
    mux = 2'd2;
    do_read(6'd63, 32'h1234_5678);
    drain();
    rst = 1;
    #1 check_reset_outputs("rst_idle");
    tick();
    rst = 0;
    for (int k = 1; k <= 30; k++) tick();
    check("ready_mid_clear", 32'(ready), 32'd0);
    rst = 1;
    #1 check_reset_outputs("rst_clear");
    tick();
    rst = 0;
    count_clear("ready_clear2");
    do_read(6'd63, 32'h0);
    do_read(6'd5, 32'h0);
    drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
